// File: rtl/nanov_operand_stage.sv
// nanoV operand stage: architectural register file plus a one-entry valid/ready operand register.
// Optional build macro NANOV_WR_BYPASS_EN forwards a same-cycle writeback into captured operands.
module nanov_operand_stage #(
  parameter int NUM_REGS = 16,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic            in_use_imm,
  input  logic [XLEN-1:0] in_imm,
  input  logic [2:0]      in_alu_op,
  input  logic [4:0]      in_rd,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [2:0]      out_op,
  output logic [4:0]      out_rd
);

  // RV32E decodes only the low four index bits, so x16..x31 alias x0..x15.
  localparam int IW = (NUM_REGS == 32) ? 5 : 4;

  logic [XLEN-1:0] regs [NUM_REGS];
  logic [IW-1:0]   rs1_idx;
  logic [IW-1:0]   rs2_idx;
  logic [IW-1:0]   wr_idx;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            accept;
  logic            unused_idx_bits;

  assign rs1_idx = in_rs1[IW-1:0];
  assign rs2_idx = in_rs2[IW-1:0];
  assign wr_idx  = wr_addr[IW-1:0];

  assign unused_idx_bits = ^{in_rs1, in_rs2, wr_addr};

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_idx != '0)) begin
      regs[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rs1_val = (rs1_idx == '0) ? '0 : regs[rs1_idx];
    rs2_val = (rs2_idx == '0) ? '0 : regs[rs2_idx];
`ifdef NANOV_WR_BYPASS_EN
    if (wr_en && (rs1_idx != '0) && (wr_idx == rs1_idx)) begin
      rs1_val = wr_data;
    end
    if (wr_en && (rs2_idx != '0) && (wr_idx == rs2_idx)) begin
      rs2_val = wr_data;
    end
`else
`endif
  end

  // Latched operands are never refreshed by later writes; upstream interlocks on hazards.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_op    <= '0;
      out_rd    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_a     <= rs1_val;
      out_b     <= in_use_imm ? in_imm : rs2_val;
      out_op    <= in_alu_op;
      out_rd    <= in_rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nanov_operand_stage.sv
// Directed bench for nanov_operand_stage (NUM_REGS=16) with a scoreboard of expected operand sets.
// Honours NANOV_WR_BYPASS_EN the same way the design does.
module tb_nanov_operand_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic        in_use_imm;
  logic [31:0] in_imm;
  logic [2:0]  in_alu_op;
  logic [4:0]  in_rd;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_op;
  logic [4:0]  out_rd;

  always #5 clk = ~clk;

  nanov_operand_stage #(.NUM_REGS(16), .XLEN(32)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_use_imm (in_use_imm),
    .in_imm     (in_imm),
    .in_alu_op  (in_alu_op),
    .in_rd      (in_rd),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_op     (out_op),
    .out_rd     (out_rd)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [4:0]  rd;
  } ops_t;

  ops_t        sb[$];
  logic [31:0] mdl [16];
  logic        mdl_valid;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          run_len  = 0;
  int          max_run  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] idx);
    logic [31:0] v;
    v = (idx[3:0] == 4'd0) ? 32'd0 : mdl[idx[3:0]];
`ifdef NANOV_WR_BYPASS_EN
    if (wr_en && (idx[3:0] != 4'd0) && (wr_addr[3:0] == idx[3:0])) v = wr_data;
`else
`endif
    return v;
  endfunction

  task automatic set_in(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic use_imm, input logic [31:0] imm,
                        input logic [2:0] op, input logic [4:0] rd);
    in_valid   = v;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_use_imm = use_imm;
    in_imm     = imm;
    in_alu_op  = op;
    in_rd      = rd;
  endtask

  task automatic set_wr(input logic en, input logic [4:0] addr, input logic [31:0] data);
    wr_en   = en;
    wr_addr = addr;
    wr_data = data;
  endtask

  // One clock: check the settled outputs, update the model, advance to just after the edge.
  task automatic tick();
    ops_t e;
    logic acc;
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, mdl_valid});
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!mdl_valid || out_ready)});
    if (out_valid) run_len++;
    else run_len = 0;
    if (run_len > max_run) max_run = run_len;
    if (mdl_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL sb_underflow observed=out_valid expected=no_output");
      end else begin
        chk("out_a", out_a, sb[0].a);
        chk("out_b", out_b, sb[0].b);
        chk("out_op", {29'd0, out_op}, {29'd0, sb[0].op});
        chk("out_rd", {27'd0, out_rd}, {27'd0, sb[0].rd});
        if (out_ready) void'(sb.pop_front());
      end
    end
    acc = in_valid && (!mdl_valid || out_ready);
    if (acc) begin
      e.a  = mread(in_rs1);
      e.b  = in_use_imm ? in_imm : mread(in_rs2);
      e.op = in_alu_op;
      e.rd = in_rd;
      sb.push_back(e);
    end
    if (acc) mdl_valid = 1'b1;
    else if (out_ready) mdl_valid = 1'b0;
    if (wr_en && (wr_addr[3:0] != 4'd0)) mdl[wr_addr[3:0]] = wr_data;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 32'd0, 3'd0, 5'd0);
    set_wr(1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = 32'd0;
    mdl_valid = 1'b0;
    rstn      = 1'b0;
    out_ready = 1'b1;
    idle();

    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_b", out_b, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // basic register path
    set_wr(1'b1, 5'd3, 32'h0000_0010); tick();
    set_wr(1'b1, 5'd4, 32'hFFFF_FFF0); tick();
    idle();
    set_in(1'b1, 5'd3, 5'd4, 1'b0, 32'd0, 3'b000, 5'd7); tick();
    idle(); tick();

    // x0 ignores writes; immediate selects b
    set_wr(1'b1, 5'd0, 32'hDEAD_BEEF); tick();
    idle();
    set_in(1'b1, 5'd0, 5'd4, 1'b1, 32'hFFFF_F800, 3'b100, 5'd1); tick();
    set_in(1'b1, 5'd3, 5'd0, 1'b0, 32'd0, 3'b111, 5'd31); tick();
    idle(); tick();

    // backpressure: A held for three stalled cycles, then B follows exactly once
    set_wr(1'b1, 5'd5, 32'h0000_0055);
    set_in(1'b1, 5'd3, 5'd4, 1'b0, 32'd0, 3'b110, 5'd2); tick();
    set_wr(1'b0, 5'd0, 32'd0);
    out_ready = 1'b0;
    set_in(1'b1, 5'd5, 5'd3, 1'b0, 32'd0, 3'b011, 5'd12);
    tick(); tick(); tick();
    out_ready = 1'b1; tick();
    idle(); tick(); tick();

    // same-cycle writeback on rs1, then read back
    set_wr(1'b1, 5'd9, 32'h1234_5678);
    set_in(1'b1, 5'd9, 5'd3, 1'b0, 32'd0, 3'b010, 5'd9); tick();
    idle();
    set_in(1'b1, 5'd9, 5'd9, 1'b0, 32'd0, 3'b000, 5'd10); tick();
    // same-cycle write to x0 and to an immediate-shadowed rs2
    set_wr(1'b1, 5'd0, 32'hCAFE_F00D);
    set_in(1'b1, 5'd0, 5'd0, 1'b0, 32'd0, 3'b100, 5'd11); tick();
    set_wr(1'b1, 5'd6, 32'h6666_0006);
    set_in(1'b1, 5'd6, 5'd6, 1'b1, 32'h0000_07FF, 3'b000, 5'd6); tick();
    idle(); tick();

    // RV32E aliasing of x17 onto x1
    set_wr(1'b1, 5'd17, 32'hA5A5_A5A5); tick();
    idle();
    set_in(1'b1, 5'd1, 5'd17, 1'b0, 32'd0, 3'b111, 5'd17); tick();
    idle(); tick();

    // eight back-to-back accepts at full throughput
    for (int i = 1; i <= 15; i++) begin
      set_wr(1'b1, 5'(i), 32'h1000_0000 + 32'(i * 3)); tick();
    end
    idle(); tick();
    max_run = 0;
    run_len = 0;
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 5'(i + 1), 5'(15 - i), 1'(i % 2), 32'hFFFF_0000 | 32'(i), 3'(i), 5'(20 + i));
      tick();
    end
    idle(); tick(); tick();
    chk("burst_len", max_run, 32'd8);

    // async reset while an operand set is held under backpressure
    out_ready = 1'b0;
    set_in(1'b1, 5'd3, 5'd4, 1'b0, 32'd0, 3'b000, 5'd3); tick();
    idle();
    set_wr(1'b1, 5'd5, 32'hFFFF_FFFF);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_a", out_a, 32'd0);
    chk("midrst_out_rd", {27'd0, out_rd}, 32'd0);
    sb.delete();
    mdl_valid = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = 32'd0;
    @(posedge clk);
    #2;
    set_wr(1'b0, 5'd0, 32'd0);
    out_ready = 1'b1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    set_in(1'b1, 5'd5, 5'd3, 1'b0, 32'd0, 3'b000, 5'd5); tick();
    idle(); tick(); tick();

    n_checks++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
